// File: rtl/data_mem_responder.sv
// Data memory responder: a word-organised little-endian store that serves one
// load/store request at a time. Each response appears a fixed number of cycles
// after the request is accepted. Misaligned, out-of-range and illegal-width
// requests are reported as errors and leave the storage untouched.
module data_mem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_width,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN-1:0] DEPTH_L = XLEN'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              write_r;
  logic [XLEN-1:0]   addr_r;
  logic [1:0]        width_r;
  logic              unsigned_r;
  logic [XLEN-1:0]   wdata_r;

  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  logic              accept_s;
  logic              enter_resp_s;
  logic              op_write_s;
  logic [XLEN-1:0]   op_addr_s;
  logic [1:0]        op_width_s;
  logic              op_unsigned_s;
  logic [XLEN-1:0]   op_wdata_s;
  logic [IDXW-1:0]   idx_s;
  logic [1:0]        lane_s;
  logic              misalign_s;
  logic              err_s;
  logic [XLEN-1:0]   cur_word_s;
  logic [XLEN-1:0]   load_val_s;
  logic [XLEN-1:0]   new_word_s;

  // Extend a byte to XLEN bits, sign- or zero-filling per the unsigned flag.
  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic uns);
    return {{(XLEN-8){b[7] & ~uns}}, b};
  endfunction

  // Extend a halfword to XLEN bits, sign- or zero-filling per the unsigned flag.
  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic uns);
    return {{(XLEN-16){h[15] & ~uns}}, h};
  endfunction

  // Select the operation fields: live inputs while idle (LATENCY=1 commits on
  // the accept edge itself), otherwise the fields captured at accept time.
  always_comb begin
    if (state_r == IDLE) begin
      op_write_s    = req_write;
      op_addr_s     = req_addr;
      op_width_s    = req_width;
      op_unsigned_s = req_unsigned;
      op_wdata_s    = req_wdata;
    end else begin
      op_write_s    = write_r;
      op_addr_s     = addr_r;
      op_width_s    = width_r;
      op_unsigned_s = unsigned_r;
      op_wdata_s    = wdata_r;
    end
  end

  // Handshake and commit-edge detection.
  always_comb begin
    accept_s     = req_valid && req_ready;
    enter_resp_s = 1'b0;
    if (state_r == IDLE) begin
      enter_resp_s = accept_s && (LATENCY == 1);
    end else if (state_r == WAIT) begin
      enter_resp_s = (cnt_r == 4'd1);
    end else begin
      enter_resp_s = 1'b0;
    end
  end

  // Address decode and legality checking.
  always_comb begin
    idx_s  = op_addr_s[IDXW+1:2];
    lane_s = op_addr_s[1:0];
    case (op_width_s)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = op_addr_s[0];
      2'd2:    misalign_s = (op_addr_s[1:0] != 2'd0);
      default: misalign_s = 1'b1;
    endcase
    err_s = misalign_s || ({2'b00, op_addr_s[XLEN-1:2]} >= DEPTH_L);
  end

  // Read the addressed word, extract the load result and build the store word.
  always_comb begin
    cur_word_s = mem[idx_s];
    new_word_s = cur_word_s;
    case (op_width_s)
      2'd0: begin
        load_val_s = ext8(cur_word_s[{lane_s, 3'b000} +: 8], op_unsigned_s);
        new_word_s[{lane_s, 3'b000} +: 8] = op_wdata_s[7:0];
      end
      2'd1: begin
        load_val_s = ext16(cur_word_s[{lane_s[1], 4'b0000} +: 16], op_unsigned_s);
        new_word_s[{lane_s[1], 4'b0000} +: 16] = op_wdata_s[15:0];
      end
      2'd2: begin
        load_val_s = cur_word_s;
        new_word_s = op_wdata_s;
      end
      default: begin
        load_val_s = '0;
        new_word_s = cur_word_s;
      end
    endcase
  end

  // Storage commit: only on the edge entering RESP, never under reset or error.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp_s && op_write_s && !err_s) begin
      mem[idx_s] <= new_word_s;
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            write_r    <= req_write;
            addr_r     <= req_addr;
            width_r    <= req_width;
            unsigned_r <= req_unsigned;
            wdata_r    <= req_wdata;
            cnt_r      <= 4'(LATENCY - 1);
            req_ready  <= 1'b0;
            if (LATENCY == 1) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= (err_s || op_write_s) ? '0 : load_val_s;
              resp_error <= err_s;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (enter_resp_s) begin
            state_r    <= RESP;
            cnt_r      <= 4'd0;
            resp_valid <= 1'b1;
            resp_rdata <= (err_s || op_write_s) ? '0 : load_val_s;
            resp_error <= err_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            state_r    <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected responses,
// a monitor pops and compares on every response handshake. A second instance
// built with LATENCY=1 checks back-to-back throughput.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [1:0]  b_req_width;
  logic        b_resp_valid, b_resp_ready, b_resp_error;
  logic [31:0] b_resp_rdata;

  int compared   = 0;
  int mismatched = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_width(req_width), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  data_mem_responder #(.XLEN(32), .DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_width(b_req_width), .req_unsigned(b_req_unsigned),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_error(b_resp_error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on each response handshake of the main instance.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_resp: got rdata %h err %b with empty scoreboard", resp_rdata, resp_error);
      end else begin
        logic [32:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk({n, "_rdata"}, resp_rdata, e[31:0]);
        chk({n, "_error"}, {31'd0, resp_error}, {31'd0, e[32]});
      end
    end
  end

  // One full transaction on the main instance; stall>0 holds resp_ready low.
  task automatic xact(input string nm, input logic wr, input logic [31:0] addr,
                      input logic [1:0] w, input logic uns, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int cyc;
    exp_q.push_back({exp_err, exp_rd});
    name_q.push_back(nm);
    if (stall > 0) resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_width = w; req_unsigned = uns; req_wdata = wd;
    chk({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    // Scramble request fields after accept: they must not affect the operation.
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom;
    req_wdata = $urandom; req_width = 2'($urandom_range(0, 3)); req_unsigned = ~uns;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'd2);
    if (stall > 0) begin
      // A competing store during the stall must be ignored.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0010;
      req_width = 2'd2; req_wdata = 32'h0000_0000;
      for (int i = 0; i < stall; i++) begin
        chk({nm, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({nm, "_hold_rdata"}, resp_rdata, exp_rd);
        chk({nm, "_hold_error"}, {31'd0, resp_error}, {31'd0, exp_err});
        chk({nm, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, "_idle_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_width = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'd0; resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'd0; b_req_width = 2'd0;
    b_req_unsigned = 1'b0; b_req_wdata = 32'd0; b_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_error", {31'd0, resp_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    xact("st_w10",      1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    xact("ld_w10",      1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    xact("st_b11",      1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFFFF5A, 32'h0,        1'b0, 0);
    xact("ld_w10_b",    1'b0, 32'h10, 2'd2, 1'b1, 32'h0,        32'hDEAD5AEF, 1'b0, 0);
    xact("ld_b13_s",    1'b0, 32'h13, 2'd0, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0, 0);
    xact("ld_b13_u",    1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        32'h000000DE, 1'b0, 0);
    xact("ld_h12_s",    1'b0, 32'h12, 2'd1, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0, 0);
    xact("st_h11_mis",  1'b1, 32'h11, 2'd1, 1'b0, 32'h0000CAFE, 32'h0,        1'b1, 0);
    xact("ld_w10_keep", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hDEAD5AEF, 1'b0, 0);
    xact("ld_width3",   1'b0, 32'h10, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    xact("ld_h10_u",    1'b0, 32'h10, 2'd1, 1'b1, 32'h0,        32'h00005AEF, 1'b0, 0);
    xact("st_h12",      1'b1, 32'h12, 2'd1, 1'b0, 32'hFFFFBEEF, 32'h0,        1'b0, 0);
    xact("ld_w10_c",    1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hBEEF5AEF, 1'b0, 0);
    xact("ld_oor",      1'b0, 32'h1000, 2'd2, 1'b0, 32'h0,      32'h0,        1'b1, 5);
    xact("ld_w10_d",    1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hBEEF5AEF, 1'b0, 0);
    xact("ld_w12_mis",  1'b0, 32'h12, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    xact("st_w20",      1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0, 0);

    // Reset on the commit edge of an in-flight store.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_width = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_abort_valid", {31'd0, resp_valid}, 32'd0);
      chk("post_abort_ready", {31'd0, req_ready}, 32'd1);
    end
    xact("ld_w20_kept", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    // LATENCY=1 instance: continuous stores, one accept every two cycles.
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h4;
    b_req_width = 2'd2; b_req_wdata = 32'h11111111;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("l1_resp_valid", {31'd0, b_resp_valid}, 32'(k % 2));
      chk("l1_req_ready", {31'd0, b_req_ready}, 32'((k + 1) % 2));
      if (k % 2 == 1) begin
        chk("l1_st_rdata", b_resp_rdata, 32'd0);
        chk("l1_st_error", {31'd0, b_resp_error}, 32'd0);
      end else begin
        b_req_wdata = 32'h1000_0000 + 32'(k);
      end
    end
    b_req_write = 1'b0;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk("l1_ld_valid", {31'd0, b_resp_valid}, 32'd1);
    chk("l1_ld_rdata", b_resp_rdata, 32'h10000006);
    @(posedge clk); #1;
    chk("l1_ld_done", {31'd0, b_resp_valid}, 32'd0);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
